// File: rtl/ask_tx_ctrl.sv
// ASK transmit framer: preamble (1,0,..), start bit 1, 8 data bits LSB first, stop bit 0.
// Every frame bit is held for a latched number of clk cycles and drives data_bit (carrier on/off).
module ask_tx_ctrl #(
    parameter int PRE_LEN  = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [PERIOD_W-1:0] bit_period,
    output logic                data_bit,
    output logic                tx_active,
    output logic                tx_done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] START    = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] STOP     = 3'd4;

    localparam logic [PERIOD_W-1:0] ONE      = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]          PRE_LAST = (PRE_LEN == 0) ? 4'd0 : 4'(PRE_LEN - 1);
    localparam logic [2:0]          FIRST    = (PRE_LEN == 0) ? START : PREAMBLE;

    logic [2:0]          state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per;
    logic [7:0]          data_q;
    logic [3:0]          pre_idx;
    logic [2:0]          bit_idx;
    logic                bit_end;

    // Gated with rst so the requester never sees a ready that the reset would override.
    assign tx_ready = (state == IDLE) && !rst;
    assign bit_end  = (cnt == per - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            per       <= '0;
            data_q    <= '0;
            pre_idx   <= '0;
            bit_idx   <= '0;
            data_bit  <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (tx_valid) begin
                    // Both the first preamble bit and the start bit are 1.
                    per       <= (bit_period == '0) ? ONE : bit_period;
                    data_q    <= tx_data;
                    cnt       <= '0;
                    pre_idx   <= '0;
                    bit_idx   <= '0;
                    data_bit  <= 1'b1;
                    tx_active <= 1'b1;
                    state     <= FIRST;
                end
            end else if (!bit_end) begin
                cnt <= cnt + ONE;
            end else begin
                cnt <= '0;
                case (state)
                    PREAMBLE: begin
                        if (pre_idx == PRE_LAST) begin
                            state    <= START;
                            data_bit <= 1'b1;
                        end else begin
                            pre_idx  <= pre_idx + 4'd1;
                            data_bit <= pre_idx[0];  // next index even -> 1
                        end
                    end
                    START: begin
                        state    <= DATA;
                        data_bit <= data_q[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            data_bit <= 1'b0;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            data_bit <= data_q[bit_idx + 3'd1];
                        end
                    end
                    STOP: begin
                        state     <= IDLE;
                        data_bit  <= 1'b0;
                        tx_active <= 1'b0;
                        tx_done   <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        data_bit  <= 1'b0;
                        tx_active <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ask_tx_ctrl.sv
// Bench for ask_tx_ctrl: PRE_LEN=8 and PRE_LEN=0 instances share stimulus; each is checked
// every cycle against a queue of expected keying bits built from the frame definition.
module tb_ask_tx_ctrl;
    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic [15:0] bit_period = 16'd1;

    logic rdy8, dbit8, act8, done8;
    logic rdy0, dbit0, act0, done0;

    int errors = 0;
    int checks = 0;

    bitq_t q8, q0;
    bit    mdone8, mdone0, acc8, acc0;

    always #5 clk = ~clk;

    ask_tx_ctrl #(.PRE_LEN(8), .PERIOD_W(16)) dut8 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy8),
        .bit_period(bit_period), .data_bit(dbit8), .tx_active(act8), .tx_done(done8)
    );

    ask_tx_ctrl #(.PRE_LEN(0), .PERIOD_W(16)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy0),
        .bit_period(bit_period), .data_bit(dbit0), .tx_active(act0), .tx_done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected data_bit value per clk cycle of the frame.
    function automatic bitq_t make_frame(input logic [7:0] d, input int per, input int pl);
        bitq_t f;
        int    p = (per == 0) ? 1 : per;
        bit    bits[$];
        for (int i = 0; i < pl; i++) bits.push_back((i % 2) == 0);
        bits.push_back(1'b1);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        bits.push_back(1'b0);
        foreach (bits[k]) for (int c = 0; c < p; c++) f.push_back(bits[k]);
        return f;
    endfunction

    task automatic model(inout bitq_t q, inout bit done, output bit acc, input int pl);
        bit busy;
        acc = 1'b0;
        if (rst) begin
            q.delete();
            done = 1'b0;
        end else begin
            busy = (q.size() > 0);
            if (busy) void'(q.pop_front());
            done = busy && (q.size() == 0);
            if (!busy && tx_valid) begin
                q   = {q, make_frame(tx_data, int'(bit_period), pl)};
                acc = 1'b1;
            end
        end
    endtask

    // Advance one clock: update models at the edge, compare both instances mid-cycle.
    task automatic step();
        @(posedge clk);
        model(q8, mdone8, acc8, 8);
        model(q0, mdone0, acc0, 0);
        @(negedge clk);
        chk("bit8",   dbit8, (q8.size() > 0) ? q8[0] : 1'b0);
        chk("act8",   act8,  q8.size() > 0);
        chk("done8",  done8, mdone8);
        chk("ready8", rdy8,  (q8.size() == 0) && !rst);
        chk("bit0",   dbit0, (q0.size() > 0) ? q0[0] : 1'b0);
        chk("act0",   act0,  q0.size() > 0);
        chk("done0",  done0, mdone0);
        chk("ready0", rdy0,  (q0.size() == 0) && !rst);
    endtask

    // Single frame from idle; returns cycles from acceptance cycle to the observed tx_done cycle.
    task automatic send(input logic [7:0] d, input logic [15:0] p, input bit inst0, output int n);
        tx_data    = d;
        bit_period = p;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        n = 1;
        while (!(inst0 ? done0 : done8) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        while ((q8.size() > 0 || q0.size() > 0 || done8 || done0) && k < 1000) begin
            step();
            k++;
        end
    endtask

    initial begin
        int  n;
        bit  seen_done;
        int  k;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ready8", rdy8, 1);

        send(8'hA5, 16'd4, 1'b0, n);
        chk("a5_len", n, 73);
        drain();

        send(8'hFF, 16'd0, 1'b0, n);
        chk("p0_len", n, 19);
        drain();

        send(8'h00, 16'd2, 1'b1, n);
        chk("pre0_len", n, 21);
        drain();

        // Back-to-back: valid held, next byte must go in on the tx_done cycle.
        tx_data = 8'h01; bit_period = 16'd3; tx_valid = 1'b1;
        step();
        tx_data = 8'h80;
        seen_done = 1'b0;
        k = 0;
        do begin
            n = done8;
            step();
            k++;
            if (acc8) seen_done = n[0];
        end while (!acc8 && k < 1000);
        tx_valid = 1'b0;
        chk("b2b_gap", seen_done, 1);
        drain();

        // Busy ignore: scramble inputs mid-frame.
        tx_data = 8'h3C; bit_period = 16'd2; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (30) begin
            tx_data    = 8'($urandom);
            bit_period = 16'($urandom_range(0, 9));
            tx_valid   = $urandom_range(0, 1) == 1;
            if (q8.size() == 0) tx_valid = 1'b0;
            step();
        end
        tx_valid = 1'b0;
        drain();

        // Reset during DATA bit 3 (bit index 12, period 2).
        tx_data = 8'hC3; bit_period = 16'd2; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (24) step();
        rst = 1'b1;
        step();
        chk("rst_mid_act", act8, 0);
        rst = 1'b0;
        step();
        chk("rst_mid_ready", rdy8, 1);
        drain();

        repeat (3000) begin
            tx_valid   = ($urandom % 3) == 0;
            tx_data    = 8'($urandom);
            bit_period = 16'($urandom_range(0, 3));
            rst        = ($urandom % 400) == 0;
            step();
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
